// File: rtl/adc_scan_ctrl.sv
// LTC2308 scan sequencer: Avalon-MM register block that drives CONVST/SCK/SDI,
// captures SDO and keeps one result register per enabled channel.

module adc_scan_ctrl #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic        scan_irq
);

    localparam int CNT_W = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, GAP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic             sck_q, sck_d;
    logic             convst_q, convst_d;
    logic             sdi_q, sdi_d;
    logic [11:0]      shift_q, shift_d;
    logic [11:0]      cfg_q, cfg_d;
    logic [7:0]       remain_q, remain_d;
    logic [2:0]       curCh_q, curCh_d;
    logic [2:0]       prevCh_q, prevCh_d;
    logic             prevValid_q, prevValid_d;
    logic             final_q, final_d;
    logic             wrPend_q, wrPend_d;
    logic             busy_q, busy_d;
    logic             run_q, run_d;
    logic             irqEn_q, irqEn_d;
    logic [7:0]       mask_q, mask_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic             irq_q, irq_d;
    logic [31:0]      readdata_q, rdNext;
    logic [7:0]       valid_q;
    logic [11:0]      result_q [8];

    logic             ctrlWr, statWr, startReq, runReq;
    logic             doSetup, setupFirst, scanEnd;
    logic [7:0]       setupRemain;
    logic [2:0]       lowCh;
    logic [2:0]       dataIdx;
    logic             unusedBits;

    function automatic logic [2:0] lowestCh(input logic [7:0] m);
        logic [2:0] ch;
        ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) ch = 3'(i);
        end
        return ch;
    endfunction

    // Single-ended, unipolar, no sleep; SDI stays low after the sixth bit.
    function automatic logic [11:0] cfgWord(input logic [2:0] ch);
        return {1'b1, ch[0], ch[2], ch[1], 1'b1, 7'b0};
    endfunction

    assign ctrlWr     = write && (address == 4'd0);
    assign statWr     = write && (address == 4'd1);
    assign startReq   = ctrlWr && writedata[1] && (writedata[15:8] != 8'd0);
    assign runReq     = run_q && (mask_q != 8'd0);
    assign dataIdx    = 3'(address - 4'd2);
    assign unusedBits = ^{read, writedata[31:16], writedata[7:3]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_d       = bit_q;
        sck_d       = sck_q;
        convst_d    = convst_q;
        sdi_d       = sdi_q;
        shift_d     = shift_q;
        cfg_d       = cfg_q;
        remain_d    = remain_q;
        curCh_d     = curCh_q;
        prevCh_d    = prevCh_q;
        prevValid_d = prevValid_q;
        final_d     = final_q;
        wrPend_d    = 1'b0;
        busy_d      = busy_q;
        run_d       = run_q;
        irqEn_d     = irqEn_q;
        mask_d      = mask_q;
        done_d      = done_q;
        overrun_d   = overrun_q;
        doSetup     = 1'b0;
        setupFirst  = 1'b0;
        setupRemain = 8'd0;
        scanEnd     = 1'b0;
        lowCh       = 3'd0;

        if (ctrlWr) begin
            run_d   = writedata[0];
            irqEn_d = writedata[2];
            mask_d  = writedata[15:8];
        end
        if (statWr) begin
            if (writedata[1]) done_d = 1'b0;
            if (writedata[2]) overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (startReq || runReq) begin
                    doSetup     = 1'b1;
                    setupFirst  = 1'b1;
                    setupRemain = startReq ? writedata[15:8] : mask_q;
                    busy_d      = 1'b1;
                end
            end
            CONV: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(1)) convst_d = 1'b0;
                if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = 4'd0;
                    sck_d   = 1'b0;
                    sdi_d   = cfg_q[11];
                end
            end
            SHIFT: begin
                if (div_q == DIV_W'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d   = 1'b1;
                        shift_d = {shift_q[10:0], adc_sdo};
                        if (bit_q == 4'd11) wrPend_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 4'd11) begin
                            state_d = GAP;
                            sdi_d   = 1'b0;
                        end else begin
                            bit_d = bit_q + 4'd1;
                            sdi_d = cfg_q[10];
                            cfg_d = {cfg_q[10:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            GAP: begin
                if (final_q) begin
                    scanEnd = 1'b1;
                    if (runReq) begin
                        doSetup     = 1'b1;
                        setupFirst  = 1'b1;
                        setupRemain = mask_q;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    doSetup     = 1'b1;
                    setupRemain = remain_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // A scan end sets done even when software clears it in the same cycle.
        if (scanEnd) begin
            if (done_q) overrun_d = 1'b1;
            done_d = 1'b1;
        end

        // Frame setup: the result shifted in next belongs to the channel configured now.
        if (doSetup) begin
            lowCh = lowestCh(setupRemain);
            if (setupRemain != 8'd0) begin
                curCh_d  = lowCh;
                remain_d = setupRemain & ~(8'd1 << lowCh);
                final_d  = 1'b0;
            end else begin
                remain_d = 8'd0;
                final_d  = 1'b1;
            end
            prevCh_d    = curCh_q;
            prevValid_d = !setupFirst;
            cfg_d       = cfgWord(curCh_d);
            state_d     = CONV;
            cnt_d       = '0;
            convst_d    = 1'b1;
        end

        irq_d = done_d && irqEn_d;
    end

    always_comb begin
        rdNext = 32'd0;
        case (address)
            4'd0: rdNext = {16'd0, mask_q, 5'd0, irqEn_q, 1'b0, run_q};
            4'd1: rdNext = {29'd0, overrun_q, done_q, busy_q};
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9:
                rdNext = {valid_q[dataIdx], 19'd0, result_q[dataIdx]};
            default: rdNext = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            bit_q       <= 4'd0;
            sck_q       <= 1'b0;
            convst_q    <= 1'b0;
            sdi_q       <= 1'b0;
            shift_q     <= 12'd0;
            cfg_q       <= 12'd0;
            remain_q    <= 8'd0;
            curCh_q     <= 3'd0;
            prevCh_q    <= 3'd0;
            prevValid_q <= 1'b0;
            final_q     <= 1'b0;
            wrPend_q    <= 1'b0;
            busy_q      <= 1'b0;
            run_q       <= 1'b0;
            irqEn_q     <= 1'b0;
            mask_q      <= 8'd0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            irq_q       <= 1'b0;
            readdata_q  <= 32'd0;
            valid_q     <= 8'd0;
            for (int i = 0; i < 8; i++) result_q[i] <= 12'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            sck_q       <= sck_d;
            convst_q    <= convst_d;
            sdi_q       <= sdi_d;
            shift_q     <= shift_d;
            cfg_q       <= cfg_d;
            remain_q    <= remain_d;
            curCh_q     <= curCh_d;
            prevCh_q    <= prevCh_d;
            prevValid_q <= prevValid_d;
            final_q     <= final_d;
            wrPend_q    <= wrPend_d;
            busy_q      <= busy_d;
            run_q       <= run_d;
            irqEn_q     <= irqEn_d;
            mask_q      <= mask_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            irq_q       <= irq_d;
            readdata_q  <= rdNext;
            if (wrPend_q && prevValid_q) begin
                valid_q[prevCh_q]  <= 1'b1;
                result_q[prevCh_q] <= shift_q;
            end
        end
    end

    assign readdata   = readdata_q;
    assign adc_convst = convst_q;
    assign adc_sck    = sck_q;
    assign adc_sdi    = sdi_q;
    assign scan_irq   = irq_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Self-checking bench for adc_scan_ctrl: a default instance and a fast
// CLK_DIV=1/CONV_CYCLES=2 instance share the bus, each with its own LTC2308 model.

module tb_adc_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] rdata0, rdata1;
    logic        convst0, sck0, sdi0, irq0;
    logic        convst1, sck1, sdi1, irq1;
    logic        sdo0 = 1'b0;
    logic        sdo1 = 1'b0;

    int compared   = 0;
    int mismatched = 0;
    int respMode   = 0;

    logic [11:0] outW0 = 12'd0, outW1 = 12'd0;
    logic [11:0] cap0 = 12'd0, cap1 = 12'd0;
    int bitN0 = 0, bitN1 = 0;
    int conv0 = 0, conv1 = 0;
    int rise0 = 0, rise1 = 0;

    typedef struct {
        int          phase;
        logic [3:0]  addr;
        logic [31:0] exp;
        string       name;
    } readVec_t;

    readVec_t vecs[$];

    always #5 clk = ~clk;

    adc_scan_ctrl #(.CLK_DIV(2), .CONV_CYCLES(80)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(rdata0),
        .adc_convst(convst0), .adc_sck(sck0), .adc_sdi(sdi0), .adc_sdo(sdo0),
        .scan_irq(irq0)
    );

    adc_scan_ctrl #(.CLK_DIV(1), .CONV_CYCLES(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(rdata1),
        .adc_convst(convst1), .adc_sck(sck1), .adc_sdi(sdi1), .adc_sdo(sdo1),
        .scan_irq(irq1)
    );

    // ADC model answers each frame with the result of the channel configured in the previous frame.
    function automatic logic [11:0] respFor(input logic [11:0] cfg);
        logic [2:0] ch;
        ch = {cfg[9], cfg[8], cfg[10]};
        return (respMode == 0) ? 12'hA5C : (12'h100 + {9'd0, ch});
    endfunction

    always @(posedge convst0) begin
        conv0++;
        outW0 = respFor(cap0);
        sdo0  = outW0[11];
        bitN0 = 0;
    end
    always @(posedge sck0) begin
        cap0 = {cap0[10:0], sdi0};
        rise0++;
    end
    always @(negedge sck0) begin
        bitN0++;
        sdo0 = (bitN0 < 12) ? outW0[11-bitN0] : 1'b0;
    end

    always @(posedge convst1) begin
        conv1++;
        outW1 = respFor(cap1);
        sdo1  = outW1[11];
        bitN1 = 0;
    end
    always @(posedge sck1) begin
        cap1 = {cap1[10:0], sdi1};
        rise1++;
    end
    always @(negedge sck1) begin
        bitN1++;
        sdo1 = (bitN1 < 12) ? outW1[11-bitN1] : 1'b0;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic readReg(input logic [3:0] a, output logic [31:0] r0, output logic [31:0] r1);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        r0   = rdata0;
        r1   = rdata1;
        read = 1'b0;
    endtask

    task automatic runVectors(input int phase);
        logic [31:0] r0, r1;
        foreach (vecs[i]) begin
            if (vecs[i].phase == phase) begin
                readReg(vecs[i].addr, r0, r1);
                checkOutput({vecs[i].name, "/d0"}, r0, vecs[i].exp);
                checkOutput({vecs[i].name, "/d1"}, r1, vecs[i].exp);
            end
        end
    endtask

    task automatic waitIdle(input string name);
        logic [31:0] r0, r1;
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 3000 && !idle; n++) begin
            readReg(4'd1, r0, r1);
            idle = !r0[0] && !r1[0];
        end
        if (!idle) timeoutFail(name);
    endtask

    task automatic waitStatus0(input int bitIdx, input string name);
        logic [31:0] r0, r1;
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            readReg(4'd1, r0, r1);
            seen = r0[bitIdx];
        end
        if (!seen) timeoutFail(name);
    endtask

    initial begin
        logic [31:0] r0, r1;
        int c0, c1, base;
        bit reached;

        vecs.push_back('{0, 4'd0,  32'h0000_0000, "rstCtrl"});
        vecs.push_back('{0, 4'd1,  32'h0000_0000, "rstStatus"});
        vecs.push_back('{0, 4'd2,  32'h0000_0000, "rstData0"});
        vecs.push_back('{0, 4'd9,  32'h0000_0000, "rstData7"});
        vecs.push_back('{0, 4'd12, 32'h0000_0000, "rstAddr12"});
        vecs.push_back('{1, 4'd2,  32'h8000_0A5C, "s1Data0"});
        vecs.push_back('{1, 4'd3,  32'h0000_0000, "s1Data1"});
        vecs.push_back('{1, 4'd1,  32'h0000_0002, "s1Status"});
        vecs.push_back('{1, 4'd0,  32'h0000_0100, "s1Ctrl"});
        vecs.push_back('{2, 4'd2,  32'h8000_0100, "s2Data0"});
        vecs.push_back('{2, 4'd3,  32'h0000_0000, "s2Data1"});
        vecs.push_back('{2, 4'd4,  32'h8000_0102, "s2Data2"});
        vecs.push_back('{2, 4'd9,  32'h8000_0107, "s2Data7"});
        vecs.push_back('{2, 4'd1,  32'h0000_0002, "s2Status"});
        vecs.push_back('{2, 4'd10, 32'h0000_0000, "s2Addr10"});
        vecs.push_back('{2, 4'd0,  32'h0000_8500, "s2Ctrl"});
        vecs.push_back('{3, 4'd1,  32'h0000_0006, "runStatus"});
        vecs.push_back('{3, 4'd2,  32'h8000_0100, "runData0"});
        vecs.push_back('{3, 4'd3,  32'h8000_0101, "runData1"});
        vecs.push_back('{4, 4'd1,  32'h0000_0000, "w1cStatus"});
        vecs.push_back('{5, 4'd0,  32'h0000_0000, "rst2Ctrl"});
        vecs.push_back('{5, 4'd1,  32'h0000_0000, "rst2Status"});
        vecs.push_back('{5, 4'd2,  32'h0000_0000, "rst2Data0"});
        vecs.push_back('{5, 4'd4,  32'h0000_0000, "rst2Data2"});
        vecs.push_back('{5, 4'd9,  32'h0000_0000, "rst2Data7"});

        reset_n   = 1'b0;
        address   = 4'd0;
        write     = 1'b0;
        read      = 1'b0;
        writedata = 32'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rstPins0", {28'd0, convst0, sck0, sdi0, irq0}, 32'd0);
        checkOutput("rstPins1", {28'd0, convst1, sck1, sdi1, irq1}, 32'd0);
        checkOutput("rstReaddata0", rdata0, 32'd0);
        runVectors(0);

        $display("[TB] single scan, mask 0x01");
        respMode = 0;
        c0 = conv0;
        c1 = conv1;
        applyStimulus(4'd0, 32'h0000_0102);
        waitIdle("s1Idle");
        checkOutput("s1Convst0", 32'(conv0 - c0), 32'd2);
        checkOutput("s1Convst1", 32'(conv1 - c1), 32'd2);
        checkOutput("s1Sdi0", {20'd0, cap0}, 32'h880);
        checkOutput("s1Sdi1", {20'd0, cap1}, 32'h880);
        runVectors(1);

        $display("[TB] scan mask 0x85");
        applyStimulus(4'd1, 32'h2);
        respMode = 1;
        c0 = conv0;
        c1 = conv1;
        applyStimulus(4'd0, 32'h0000_8502);
        waitIdle("s2Idle");
        checkOutput("s2Convst0", 32'(conv0 - c0), 32'd4);
        checkOutput("s2Convst1", 32'(conv1 - c1), 32'd4);
        checkOutput("s2Sdi0", {20'd0, cap0}, 32'hF80);
        runVectors(2);

        $display("[TB] continuous scan with irq and overrun");
        applyStimulus(4'd1, 32'h6);
        applyStimulus(4'd0, 32'h0000_0305);
        waitStatus0(1, "runDone");
        readReg(4'd1, r0, r1);
        checkOutput("runFirstStatus", r0, 32'h3);
        checkOutput("runIrqAfterFirst", {31'd0, irq0}, 32'd1);
        waitStatus0(2, "runOverrun");
        applyStimulus(4'd0, 32'h0000_0304);
        waitIdle("runIdle");
        runVectors(3);
        checkOutput("runIrqHeld", {30'd0, irq1, irq0}, 32'h3);
        applyStimulus(4'd1, 32'h6);
        runVectors(4);
        checkOutput("w1cIrq", {30'd0, irq1, irq0}, 32'h0);

        $display("[TB] start with empty mask, start while busy");
        c0 = conv0;
        applyStimulus(4'd0, 32'h0000_0002);
        repeat (20) @(negedge clk);
        readReg(4'd1, r0, r1);
        checkOutput("mask0Status0", r0, 32'h0);
        checkOutput("mask0Status1", r1, 32'h0);
        checkOutput("mask0Convst", 32'(conv0 - c0), 32'd0);
        c0 = conv0;
        c1 = conv1;
        applyStimulus(4'd0, 32'h0000_0102);
        repeat (10) @(negedge clk);
        applyStimulus(4'd0, 32'h0000_0102);
        waitIdle("busyStartIdle");
        checkOutput("busyStartConvst0", 32'(conv0 - c0), 32'd2);
        checkOutput("busyStartConvst1", 32'(conv1 - c1), 32'd2);

        $display("[TB] reset during the 6th SCK pulse");
        base = rise0;
        applyStimulus(4'd0, 32'h0000_0102);
        reached = 1'b0;
        for (int n = 0; n < 2000 && !reached; n++) begin
            @(negedge clk);
            reached = (rise0 - base) >= 6;
        end
        if (!reached) begin
            timeoutFail("midFrameSck6");
        end else begin
            checkOutput("sckHighBeforeReset", {31'd0, sck0}, 32'd1);
            reset_n = 1'b0;
            #1;
            checkOutput("rstMidSck", {31'd0, sck0}, 32'd0);
            checkOutput("rstMidConvst", {31'd0, convst0}, 32'd0);
            checkOutput("rstMidReaddata", rdata0, 32'd0);
        end
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        runVectors(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
